// File: rtl/integral_image_buffer.sv
// rtl/integral_image_buffer.sv - integral image builder and 3-cycle-latency read store for one frame
//
// Builds ii(x,y) = sum of pix(i,j) for i<=x, j<=y from a raster pixel stream
// and holds the finished frame for random-access reads by the classifiers.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pix_valid       pixel present this cycle
//   sof             start of frame, qualifies pixel (0,0) together with pix_valid
//   pix_data        unsigned grayscale pixel, raster order
//   frame_release   consumer done with the stored frame (sampled in READY)
//   rd_addr         read address y*II_WIDTH + x
//   rd_data         integral value, valid 3 cycles after rd_addr; 0 when out of range
//   frame_ready     stored frame complete and stable
//   frame_done      one-cycle pulse on frame completion
//   sof_error       one-cycle pulse: frame restarted by sof while building
//   overrun         one-cycle pulse: sof while READY and not released (frame dropped)
module integral_image_buffer #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int PIX_W     = 4,
    parameter int DATA_W    = 21,
    parameter int ADDR_W    = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic                     sof,
    input  logic [PIX_W-1:0]         pix_data,
    input  logic                     frame_release,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     frame_ready,
    output logic                     frame_done,
    output logic                     sof_error,
    output logic                     overrun
);

    localparam int TOTAL = II_WIDTH * II_HEIGHT;
    localparam int XW    = $clog2(II_WIDTH);
    localparam int YW    = $clog2(II_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUILD,
        S_READY
    } state_t;

    state_t        state, state_next;
    logic [XW-1:0] x, x_next, cur_x;
    logic [YW-1:0] y, y_next, cur_y;
    logic          start, accept, last;
    logic          frame_done_next, sof_error_next, overrun_next;

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        start           = 1'b0;
        accept          = 1'b0;
        cur_x           = x;
        cur_y           = y;
        last            = 1'b0;
        x_next          = x;
        y_next          = y;
        frame_done_next = 1'b0;
        sof_error_next  = 1'b0;
        overrun_next    = 1'b0;

        // A qualified sof always restarts at (0,0), except in READY where the
        // stored frame is still owned by the consumer unless released now.
        start  = pix_valid && sof &&
                 (state == S_IDLE || state == S_BUILD ||
                  (state == S_READY && frame_release));
        accept = start || (pix_valid && state == S_BUILD);

        if (start) begin
            cur_x = '0;
            cur_y = '0;
        end

        last = accept && (cur_x == XW'(II_WIDTH - 1)) && (cur_y == YW'(II_HEIGHT - 1));

        if (accept) begin
            if (cur_x == XW'(II_WIDTH - 1)) begin
                x_next = '0;
                y_next = last ? '0 : cur_y + YW'(1);
            end else begin
                x_next = cur_x + XW'(1);
                y_next = cur_y;
            end
        end

        case (state)
            S_IDLE:  if (start) state_next = S_BUILD;
            S_BUILD: if (last) state_next = S_READY;
            S_READY: if (frame_release) state_next = start ? S_BUILD : S_IDLE;
            default: state_next = S_IDLE;
        endcase

        frame_done_next = last;
        sof_error_next  = (state == S_BUILD) && pix_valid && sof;
        overrun_next    = (state == S_READY) && pix_valid && sof && !frame_release;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            sof_error   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            x           <= x_next;
            y           <= y_next;
            frame_ready <= (state_next == S_READY);
            frame_done  <= frame_done_next;
            sof_error   <= sof_error_next;
            overrun     <= overrun_next;
        end
    end

    // ------------------------------------------------------------------
    // Integral datapath: stage 1 captures the running row sum and the
    // previous row's integral for this column; stage 2 adds them and writes
    // both the line buffer and the frame store.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] row_sum;
    logic [DATA_W-1:0] line_rd;
    logic [DATA_W-1:0] ii;
    logic              s1_valid;
    logic              s1_top;
    logic [XW-1:0]     s1_x;
    logic [ADDR_W-1:0] s1_addr;

    logic [DATA_W-1:0] line_buf [0:II_WIDTH-1];
    logic [DATA_W-1:0] mem      [0:TOTAL-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            row_sum  <= '0;
            s1_valid <= 1'b0;
            s1_top   <= 1'b0;
            s1_x     <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                row_sum <= ((cur_x == '0) ? '0 : row_sum) + DATA_W'(pix_data);
                s1_top  <= (cur_y == '0);
                s1_x    <= cur_x;
                s1_addr <= ADDR_W'(cur_y) * ADDR_W'(II_WIDTH) + ADDR_W'(cur_x);
            end
        end
    end

    // Row 0 has no row above; the line buffer may hold a stale frame there.
    assign ii = row_sum + (s1_top ? '0 : line_rd);

    // ------------------------------------------------------------------
    // Read pipeline: address reg -> RAM reg -> output reg
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_in_range;
    logic              oor_q;
    logic [DATA_W-1:0] ram_q;

    assign rd_in_range = (rd_addr_q < ADDR_W'(TOTAL));

    // Storage arrays carry no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_rd <= line_buf[cur_x];
        end
        if (s1_valid) begin
            line_buf[s1_x] <= ii;
            mem[s1_addr]   <= ii;
        end
        // A same-cycle write to the read address returns the old value.
        ram_q <= mem[rd_in_range ? rd_addr_q : '0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            oor_q     <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_addr_q <= rd_addr;
            oor_q     <= !rd_in_range;
            rd_data   <= oor_q ? '0 : $signed(ram_q);
        end
    end

endmodule

// File: tb/tb_integral_image_buffer.sv
// tb/tb_integral_image_buffer.sv - self-checking bench for integral_image_buffer
module tb_integral_image_buffer;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int TOTAL = W * H;

    logic               clk = 1'b0;
    logic               rst;
    logic               pix_valid;
    logic               sof;
    logic [3:0]         pix_data;
    logic               frame_release;
    logic [14:0]        rd_addr;
    logic signed [20:0] rd_data;
    logic               frame_ready;
    logic               frame_done;
    logic               sof_error;
    logic               overrun;

    always #5 clk = ~clk;

    integral_image_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .sof           (sof),
        .pix_data      (pix_data),
        .frame_release (frame_release),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_ready   (frame_ready),
        .frame_done    (frame_done),
        .sof_error     (sof_error),
        .overrun       (overrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int serr_cnt = 0;
    int ovr_cnt  = 0;

    typedef struct {
        int    due;
        int    exp;
        string name;
    } rd_t;
    rd_t rq[$];

    typedef struct {
        string name;
        int    addr;
        int    exp;
    } vec_t;
    vec_t ones_tab[7];

    int ref_ii[TOTAL];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse counters and fixed-latency read checking, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (sof_error)  serr_cnt++;
        if (overrun)    ovr_cnt++;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            check(rq[0].name, longint'(rd_data), longint'(rq[0].exp));
            rq.delete(0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v, input logic s, input logic [3:0] p, input logic rel);
        pix_valid     = v;
        sof           = s;
        pix_data      = p;
        frame_release = rel;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] p, input logic rel);
        set_pix(v, s, p, rel);
        step();
    endtask

    task automatic issue_read(input string name, input int addr, input int exp);
        logic [31:0] a;
        a       = addr;
        rd_addr = a[14:0];
        rq.push_back('{cyc + 3, exp, name});
        step();
    endtask

    // Reference integral from the 2-D prefix-sum identity.
    task automatic build_ramp_model();
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                int v;
                v = (xx + yy) % 16;
                if (xx > 0)            v += ref_ii[yy * W + xx - 1];
                if (yy > 0)            v += ref_ii[(yy - 1) * W + xx];
                if (xx > 0 && yy > 0)  v -= ref_ii[(yy - 1) * W + xx - 1];
                ref_ii[yy * W + xx] = v;
            end
        end
    endtask

    initial begin
        ones_tab[0] = '{"ones_0",      0,     1};
        ones_tab[1] = '{"ones_1",      1,     2};
        ones_tab[2] = '{"ones_161",    161,   4};
        ones_tab[3] = '{"ones_19199",  19199, 19200};
        ones_tab[4] = '{"ones_160",    160,   2};
        ones_tab[5] = '{"oor_19200",   19200, 0};
        ones_tab[6] = '{"oor_32767",   32767, 0};

        rst     = 1'b1;
        rd_addr = '0;
        set_pix(0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        check("reset_rd_data",     longint'(rd_data), 0);
        check("reset_frame_ready", frame_ready, 0);
        check("reset_frame_done",  frame_done, 0);
        check("reset_sof_error",   sof_error, 0);
        check("reset_overrun",     overrun, 0);
        rst = 1'b0;
        step();

        // Partial frame abandoned by reset.
        for (int i = 0; i < 1000; i++) drive(1, i == 0, 4'd1, 0);
        rst = 1'b1;
        set_pix(1, 0, 4'd1, 0);
        step();
        @(negedge clk);
        check("midrst_frame_ready", frame_ready, 0);
        check("midrst_frame_done",  frame_done, 0);
        check("midrst_sof_error",   sof_error, 0);
        check("midrst_overrun",     overrun, 0);
        check("midrst_rd_data",     longint'(rd_data), 0);
        rst = 1'b0;
        // Pixels without sof in IDLE must be ignored.
        for (int i = 0; i < 5; i++) drive(1, 0, 4'($urandom_range(0, 15)), 0);

        // All-ones frame, restarted by sof after 500 pixels.
        for (int i = 0; i < 500; i++) drive(1, i == 0, 4'd1, 0);
        for (int i = 0; i < TOTAL; i++) drive(1, i == 0, 4'd1, 0);
        set_pix(0, 0, 0, 0);
        @(negedge clk);
        check("f1_done_pulse", frame_done, 1);
        step();
        @(negedge clk);
        check("f1_done_low", frame_done, 0);
        step();
        @(negedge clk);
        check("f1_done_cnt",   done_cnt, 1);
        check("f1_sof_err_cnt", serr_cnt, 1);
        check("f1_ready",      frame_ready, 1);
        step();
        foreach (ones_tab[i]) issue_read(ones_tab[i].name, ones_tab[i].addr, ones_tab[i].exp);
        repeat (4) step();

        // sof in READY without release: overrun, stored frame untouched.
        set_pix(1, 1, 4'd7, 0);
        issue_read("ovr_19199", 19199, 19200);
        set_pix(1, 0, 4'd9, 0);
        issue_read("ovr_0", 0, 1);
        issue_read("ovr_161", 161, 4);
        set_pix(0, 0, 0, 0);
        repeat (4) step();
        @(negedge clk);
        check("ovr_cnt",   ovr_cnt, 1);
        check("ovr_ready", frame_ready, 1);

        // Release together with sof: BUILD starts on that pixel (all-15 frame).
        drive(1, 1, 4'd15, 1);
        @(negedge clk);
        check("rel_sof_ready_fall", frame_ready, 0);
        for (int i = 1; i < TOTAL; i++) drive(1, 0, 4'd15, 0);
        set_pix(0, 0, 0, 0);
        @(negedge clk);
        check("f2_done_pulse", frame_done, 1);
        step();
        step();
        @(negedge clk);
        check("f2_done_cnt",  done_cnt, 2);
        check("f2_ovr_cnt",   ovr_cnt, 1);
        check("f2_serr_cnt",  serr_cnt, 1);
        check("f2_ready",     frame_ready, 1);
        step();
        issue_read("f15_19199", 19199, 288000);
        issue_read("f15_159", 159, 2400);
        for (int i = 0; i < 8; i++) issue_read($sformatf("f15_b2b_%0d", i), i, 15 * (i + 1));
        repeat (4) step();

        // Plain release returns to IDLE; stray pixels without sof ignored.
        drive(0, 0, 0, 1);
        @(negedge clk);
        check("rel_ready_fall", frame_ready, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 4'($urandom_range(0, 15)), 0);

        // Gapped raster ramp against the reference model.
        build_ramp_model();
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                while ($urandom_range(0, 15) == 0)
                    drive(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
                drive(1, (xx == 0 && yy == 0), 4'((xx + yy) % 16), 0);
            end
        end
        set_pix(0, 0, 0, 0);
        @(negedge clk);
        check("f3_done_pulse", frame_done, 1);
        step();
        step();
        @(negedge clk);
        check("f3_done_cnt", done_cnt, 3);
        check("f3_ready",    frame_ready, 1);
        step();
        for (int a = 0; a < TOTAL; a++) issue_read($sformatf("ramp_%0d", a), a, ref_ii[a]);
        issue_read("ramp_oor_19200", 19200, 0);
        issue_read("ramp_oor_32767", 32767, 0);
        repeat (5) step();
        @(negedge clk);
        check("read_queue_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
